// File: rtl/pong_pkg.sv
// Shared constants and FSM state encoding for the pong ball controller.
// Holds the default screen, paddle and ball geometry, the serve speeds and
// the winning score. Everything here is a default; the top module exposes
// the same values as overridable parameters.
package pong_pkg;

    localparam int SCREEN_WIDTH_C  = 640;
    localparam int SCREEN_HEIGHT_C = 480;
    localparam int PADDLE_WIDTH_C  = 20;
    localparam int PADDLE_HEIGHT_C = 80;
    localparam int BALL_SIZE_C     = 10;
    localparam int INIT_VX_C       = 4;
    localparam int INIT_VY_C       = 2;
    localparam int WIN_SCORE_C     = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_CHK_P1    = 3'd2,
        S_CHK_P2    = 3'd3,
        S_WALL      = 3'd4,
        S_MOVE      = 3'd5,
        S_EDGE      = 3'd6
    } state_t;

endpackage

// File: rtl/paddle_hit_unit.sv
// Combinational paddle collision check for one paddle at a time.
// The caller selects the paddle with 'side' (0 = left, 1 = right) and feeds
// that paddle's top edge; the unit reports a hit and the velocity the ball
// should take after bouncing. Without a hit the velocity passes through.
//
// Ports:
//   side      in   0 checks the left paddle, 1 the right paddle
//   paddle_y  in   unsigned top edge of the selected paddle
//   ball_x/y  in   signed ball top-left position
//   vx/vy     in   signed current velocity
//   hit       out  ball is touching the selected paddle while moving toward it
//   new_vx/vy out  velocity after the bounce (unchanged when hit = 0)
//
// Build option: BALL_SPEEDUP_EN makes every bounce add 1 to |vx|, capped at
// twice the serve speed; otherwise |vx| is always the serve speed.
module paddle_hit_unit
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_C,
    parameter int PADDLE_WIDTH  = PADDLE_WIDTH_C,
    parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_C,
    parameter int BALL_SIZE     = BALL_SIZE_C,
    parameter int INIT_VX       = INIT_VX_C
) (
    input  logic        side,
    input  logic [15:0] paddle_y,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
    input  logic [15:0] vx,
    input  logic [15:0] vy,
    output logic        hit,
    output logic [15:0] new_vx,
    output logic [15:0] new_vy
);

    localparam logic signed [15:0] LEFT_LIMIT  = 16'(PADDLE_WIDTH + 2);
    localparam logic signed [15:0] RIGHT_LIMIT = 16'(SCREEN_WIDTH - PADDLE_WIDTH - 2 - BALL_SIZE);
    localparam logic signed [17:0] HEIGHT      = 18'(PADDLE_HEIGHT);
    localparam logic signed [17:0] THIRD       = 18'(PADDLE_HEIGHT / 3);
    localparam logic signed [17:0] TWO_THIRDS  = 18'(2 * (PADDLE_HEIGHT / 3));
`ifdef BALL_SPEEDUP_EN
    localparam logic signed [15:0] MAX_VX      = 16'(2 * INIT_VX);
    logic signed [15:0] vx_mag;
`endif

    logic signed [15:0] sx;
    logic signed [15:0] svx;
    logic signed [15:0] svy;
    logic signed [15:0] vy_mag;
    logic signed [15:0] mag_next;
    logic signed [17:0] offset;
    logic               x_ok;
    logic               y_ok;

    always_comb begin
        sx  = $signed(ball_x);
        svx = $signed(vx);
        svy = $signed(vy);

        // 18-bit signed so an unsigned paddle edge and a negative ball_y
        // compare correctly.
        offset = $signed({{2{ball_y[15]}}, ball_y}) - $signed({2'b00, paddle_y});
        y_ok   = (offset >= 18'sd0) && (offset < HEIGHT);

        if (side) begin
            x_ok = !svx[15] && (svx != 16'sd0) && (sx >= RIGHT_LIMIT);
        end else begin
            x_ok = svx[15] && (sx <= LEFT_LIMIT);
        end
        hit = x_ok && y_ok;

        vy_mag = svy[15] ? -svy : svy;
`ifdef BALL_SPEEDUP_EN
        vx_mag   = svx[15] ? -svx : svx;
        mag_next = (vx_mag >= MAX_VX) ? MAX_VX : vx_mag + 16'sd1;
`else
        mag_next = 16'(INIT_VX);
`endif

        new_vx = svx;
        new_vy = svy;
        if (hit) begin
            new_vx = svx[15] ? mag_next : -mag_next;
            if (offset < THIRD) begin
                new_vy = -vy_mag;
            end else if (offset >= TWO_THIRDS) begin
                new_vy = vy_mag;
            end
        end
    end

endmodule

// File: rtl/ball_motion_controller.sv
// Pong ball motion controller. One frame_tick runs a fixed five-cycle update:
// paddle checks (left then right, sharing one paddle_hit_unit), wall bounce,
// position update, and edge/score handling with re-serve from the centre.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   start                  pulse; serves a new game when idle
//   frame_tick             pulse per video frame; starts one update
//   paddle1_y, paddle2_y   unsigned top edges of left / right paddles
//   ball_x, ball_y         signed ball top-left position
//   ball_vx, ball_vy       signed ball velocity
//   score1, score2         player scores
//   busy                   update sequence in progress
//   update_done            pulse in the last cycle of an update
//   game_over              set when a player reaches WIN_SCORE
//   tick_overrun           sticky; a frame_tick arrived while busy
//
// Build option: BALL_SPEEDUP_EN (see paddle_hit_unit) speeds the ball up on
// every paddle bounce.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | no game running; start serves a new game
// WAIT_TICK  | game running, waiting for the next frame_tick
// CHK_P1     | left paddle bounce check
// CHK_P2     | right paddle bounce check (sees velocity after CHK_P1)
// WALL       | top/bottom wall bounce
// MOVE       | position += velocity
// EDGE       | score on left/right exit, re-serve, win detection
module ball_motion_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_C,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_C,
    parameter int PADDLE_WIDTH  = PADDLE_WIDTH_C,
    parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_C,
    parameter int BALL_SIZE     = BALL_SIZE_C,
    parameter int INIT_VX       = INIT_VX_C,
    parameter int INIT_VY       = INIT_VY_C,
    parameter int WIN_SCORE     = WIN_SCORE_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [15:0] paddle1_y,
    input  logic [15:0] paddle2_y,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [15:0] ball_vx,
    output logic [15:0] ball_vy,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        busy,
    output logic        update_done,
    output logic        game_over,
    output logic        tick_overrun
);

    localparam logic signed [15:0] CENTRE_X   = 16'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic signed [15:0] CENTRE_Y   = 16'((SCREEN_HEIGHT - BALL_SIZE) / 2);
    localparam logic signed [15:0] BOTTOM_Y   = 16'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic signed [15:0] RIGHT_EDGE = 16'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic signed [15:0] SERVE_VX   = 16'(INIT_VX);
    localparam logic signed [15:0] SERVE_VY   = 16'(INIT_VY);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

    state_t             state;
    logic signed [15:0] x_q;
    logic signed [15:0] y_q;
    logic signed [15:0] vx_q;
    logic signed [15:0] vy_q;

    logic        side;
    logic [15:0] paddle_sel;
    logic        hit;
    logic [15:0] hit_vx;
    logic [15:0] hit_vy;
    logic [3:0]  score1_inc;
    logic [3:0]  score2_inc;
    logic        wall_bounce;

    assign side       = (state == S_CHK_P2);
    assign paddle_sel = side ? paddle2_y : paddle1_y;
    assign score1_inc = score1 + 4'd1;
    assign score2_inc = score2 + 4'd1;
    assign wall_bounce = (vy_q[15] && (y_q <= 16'sd0)) ||
                         (!vy_q[15] && (vy_q != 16'sd0) && (y_q >= BOTTOM_Y));

    paddle_hit_unit #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .PADDLE_WIDTH  (PADDLE_WIDTH),
        .PADDLE_HEIGHT (PADDLE_HEIGHT),
        .BALL_SIZE     (BALL_SIZE),
        .INIT_VX       (INIT_VX)
    ) u_hit (
        .side     (side),
        .paddle_y (paddle_sel),
        .ball_x   (x_q),
        .ball_y   (y_q),
        .vx       (vx_q),
        .vy       (vy_q),
        .hit      (hit),
        .new_vx   (hit_vx),
        .new_vy   (hit_vy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            x_q          <= CENTRE_X;
            y_q          <= CENTRE_Y;
            vx_q         <= 16'sd0;
            vy_q         <= 16'sd0;
            score1       <= 4'd0;
            score2       <= 4'd0;
            busy         <= 1'b0;
            update_done  <= 1'b0;
            game_over    <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            update_done <= 1'b0;
            if (frame_tick && busy) begin
                tick_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        score1    <= 4'd0;
                        score2    <= 4'd0;
                        game_over <= 1'b0;
                        x_q       <= CENTRE_X;
                        y_q       <= CENTRE_Y;
                        vx_q      <= SERVE_VX;
                        vy_q      <= SERVE_VY;
                        state     <= S_WAIT_TICK;
                    end
                end

                S_WAIT_TICK: begin
                    if (frame_tick) begin
                        busy  <= 1'b1;
                        state <= S_CHK_P1;
                    end
                end

                S_CHK_P1, S_CHK_P2: begin
                    if (hit) begin
                        vx_q <= $signed(hit_vx);
                        vy_q <= $signed(hit_vy);
                    end
                    state <= (state == S_CHK_P1) ? S_CHK_P2 : S_WALL;
                end

                S_WALL: begin
                    if (wall_bounce) begin
                        vy_q <= -vy_q;
                    end
                    state <= S_MOVE;
                end

                S_MOVE: begin
                    x_q         <= x_q + vx_q;
                    y_q         <= y_q + vy_q;
                    update_done <= 1'b1;
                    state       <= S_EDGE;
                end

                S_EDGE: begin
                    busy  <= 1'b0;
                    state <= S_WAIT_TICK;
                    if (x_q[15]) begin
                        // Left player conceded: serve back toward the left.
                        score2 <= score2_inc;
                        x_q    <= CENTRE_X;
                        y_q    <= CENTRE_Y;
                        vx_q   <= -SERVE_VX;
                        vy_q   <= SERVE_VY;
                        if (score2_inc == WIN) begin
                            game_over <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else if (x_q > RIGHT_EDGE) begin
                        score1 <= score1_inc;
                        x_q    <= CENTRE_X;
                        y_q    <= CENTRE_Y;
                        vx_q   <= SERVE_VX;
                        vy_q   <= SERVE_VY;
                        if (score1_inc == WIN) begin
                            game_over <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign ball_x  = x_q;
    assign ball_y  = y_q;
    assign ball_vx = vx_q;
    assign ball_vy = vy_q;

endmodule

// File: tb/tb_ball_motion_controller.sv
module tb_ball_motion_controller;

    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int PW   = 20;
    localparam int PH   = 80;
    localparam int BS   = 10;
    localparam int IVX  = 4;
    localparam int IVY  = 2;
    localparam int WIN  = 7;
`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
    localparam int EXP_VX3 = 7;
    localparam int EXP_VX8 = 8;
`else
    localparam bit SPEEDUP = 1'b0;
    localparam int EXP_VX3 = 4;
    localparam int EXP_VX8 = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        frame_tick;
    logic [15:0] paddle1_y;
    logic [15:0] paddle2_y;
    logic [15:0] ball_x;
    logic [15:0] ball_y;
    logic [15:0] ball_vx;
    logic [15:0] ball_vy;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic        busy;
    logic        update_done;
    logic        game_over;
    logic        tick_overrun;

    always #5 clk = ~clk;

    ball_motion_controller #(
        .SCREEN_WIDTH (SW), .SCREEN_HEIGHT (SH), .PADDLE_WIDTH (PW),
        .PADDLE_HEIGHT (PH), .BALL_SIZE (BS), .INIT_VX (IVX),
        .INIT_VY (IVY), .WIN_SCORE (WIN)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .frame_tick (frame_tick),
        .paddle1_y (paddle1_y), .paddle2_y (paddle2_y),
        .ball_x (ball_x), .ball_y (ball_y), .ball_vx (ball_vx), .ball_vy (ball_vy),
        .score1 (score1), .score2 (score2), .busy (busy),
        .update_done (update_done), .game_over (game_over),
        .tick_overrun (tick_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole-frame behaviour with plain integers.
    int m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_hits;
    bit m_over;

    function automatic int wrap16(int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampp(int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model_serve(int dir_vx);
        m_x  = (SW - BS) / 2;
        m_y  = (SH - BS) / 2;
        m_vx = dir_vx;
        m_vy = IVY;
    endtask

    task automatic model_reset();
        m_x = (SW - BS) / 2; m_y = (SH - BS) / 2;
        m_vx = 0; m_vy = 0; m_s1 = 0; m_s2 = 0; m_over = 1'b0; m_hits = 0;
    endtask

    task automatic model_start();
        m_s1 = 0; m_s2 = 0; m_over = 1'b0; m_hits = 0;
        model_serve(IVX);
    endtask

    task automatic model_hit(int off);
        int mag;
        m_hits++;
        mag = iabs(m_vx);
        if (SPEEDUP) mag = (mag + 1 > 2 * IVX) ? 2 * IVX : mag + 1;
        m_vx = (m_vx < 0) ? mag : -mag;
        if (off < PH / 3) m_vy = -iabs(m_vy);
        else if (off >= 2 * (PH / 3)) m_vy = iabs(m_vy);
    endtask

    task automatic model_frame(int p1, int p2);
        if (m_vx < 0 && m_x <= PW + 2 && m_y >= p1 && m_y < p1 + PH) model_hit(m_y - p1);
        if (m_vx > 0 && m_x >= SW - PW - 2 - BS && m_y >= p2 && m_y < p2 + PH) model_hit(m_y - p2);
        if ((m_vy < 0 && m_y <= 0) || (m_vy > 0 && m_y >= SH - BS)) m_vy = -m_vy;
        m_x = wrap16(m_x + m_vx);
        m_y = wrap16(m_y + m_vy);
        if (m_x < 0) begin
            m_s2++;
            model_serve(-IVX);
            if (m_s2 == WIN) m_over = 1'b1;
        end else if (m_x > SW - BS) begin
            m_s1++;
            model_serve(IVX);
            if (m_s1 == WIN) m_over = 1'b1;
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".x"},    $signed(ball_x),  m_x);
        chk({tag, ".y"},    $signed(ball_y),  m_y);
        chk({tag, ".vx"},   $signed(ball_vx), m_vx);
        chk({tag, ".vy"},   $signed(ball_vy), m_vy);
        chk({tag, ".s1"},   int'(score1),     m_s1);
        chk({tag, ".s2"},   int'(score2),     m_s2);
        chk({tag, ".over"}, int'(game_over),  int'(m_over));
    endtask

    // One full frame update; checks tick-to-done latency and steps the model.
    task automatic do_frame(int p1, int p2);
        int lat;
        @(negedge clk);
        paddle1_y  = 16'(p1);
        paddle2_y  = 16'(p2);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        lat = 1;
        while (!update_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 5);
        @(negedge clk);
        model_frame(p1, p2);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_tick_ignored(string tag);
        int dones;
        int busies;
        dones = 0;
        busies = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (update_done) dones++;
            if (busy) busies++;
            @(negedge clk);
        end
        chk({tag, ".done_count"}, dones, 0);
        chk({tag, ".busy_count"}, busies, 0);
    endtask

    typedef struct {
        int p1, p2, n;
        int x, y, vx, vy, s1, s2;
    } vec_t;

    initial begin
        rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0;
        paddle1_y = 16'd0; paddle2_y = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst.x", $signed(ball_x), 315);
        chk("rst.y", $signed(ball_y), 235);
        chk("rst.vx", $signed(ball_vx), 0);
        chk("rst.vy", $signed(ball_vy), 0);
        chk("rst.scores", int'({score1, score2}), 0);
        chk("rst.flags", int'({busy, update_done, game_over, tick_overrun}), 0);
        rst_n = 1'b1;

        idle_tick_ignored("idle_before_start");
        chk("idle_no_overrun", int'(tick_overrun), 0);

        pulse_start();
        chk("serve.vx", $signed(ball_vx), 4);
        chk("serve.vy", $signed(ball_vy), 2);
        chk("serve.busy", int'(busy), 0);

        do_frame(0, 0);
        chk("first.x", $signed(ball_x), 319);
        chk("first.y", $signed(ball_y), 237);

`ifndef BALL_SPEEDUP_EN
        begin
            vec_t tbl[9];
            tbl[0] = '{0,   373, 73,  611, 383,  4,  2, 0, 0};
            tbl[1] = '{0,   373, 1,   607, 381, -4, -2, 0, 0};
            tbl[2] = '{200, 0,   151, 3,   79,  -4, -2, 0, 0};
            tbl[3] = '{200, 0,   1,   315, 235, -4,  2, 0, 1};
            tbl[4] = '{0,   0,   1,   311, 237, -4,  2, 0, 1};
            tbl[5] = '{0,   0,   73,  19,  383, -4,  2, 0, 1};
            tbl[6] = '{343, 0,   1,   23,  385,  4,  2, 0, 1};
            tbl[7] = '{0,   0,   43,  195, 471,  4,  2, 0, 1};
            tbl[8] = '{0,   0,   1,   199, 469,  4, -2, 0, 1};
            for (int i = 0; i < 9; i++) begin
                repeat (tbl[i].n) do_frame(tbl[i].p1, tbl[i].p2);
                chk($sformatf("tbl%0d.x", i),  $signed(ball_x),  tbl[i].x);
                chk($sformatf("tbl%0d.y", i),  $signed(ball_y),  tbl[i].y);
                chk($sformatf("tbl%0d.vx", i), $signed(ball_vx), tbl[i].vx);
                chk($sformatf("tbl%0d.vy", i), $signed(ball_vy), tbl[i].vy);
                chk($sformatf("tbl%0d.s1", i), int'(score1),     tbl[i].s1);
                chk($sformatf("tbl%0d.s2", i), int'(score2),     tbl[i].s2);
            end
        end
`endif

        // Second tick two cycles into a running update
        begin
            int dones;
            dones = 0;
            @(negedge clk);
            paddle1_y = 16'd0; paddle2_y = 16'd0;
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            for (int i = 0; i < 15; i++) begin
                if (update_done) dones++;
                @(negedge clk);
            end
            model_frame(0, 0);
            chk("overrun.flag", int'(tick_overrun), 1);
            chk("overrun.updates", dones, 1);
            check_model("overrun");
        end

        // Randomised play with paddles often placed on the ball
        for (int f = 0; f < 200; f++) begin
            int p1, p2;
            if (m_over) pulse_start();
            p1 = ($urandom_range(0, 1) == 1) ? clampp(m_y - int'($urandom_range(0, 79)))
                                             : int'($urandom_range(0, 479));
            p2 = ($urandom_range(0, 1) == 1) ? clampp(m_y - int'($urandom_range(0, 79)))
                                             : int'($urandom_range(0, 479));
            do_frame(p1, p2);
            check_model("rand");
        end

        // Reset in the MOVE cycle
        if (m_over) pulse_start();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("move.busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.x", $signed(ball_x), 315);
        chk("midrst.y", $signed(ball_y), 235);
        chk("midrst.vx", $signed(ball_vx), 0);
        chk("midrst.vy", $signed(ball_vy), 0);
        @(posedge clk);
        #1;
        chk("midrst.scores", int'({score1, score2}), 0);
        chk("midrst.flags", int'({busy, update_done, game_over, tick_overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_tick_ignored("idle_after_reset");

        // Paddles tracking the ball: repeated bounces
        pulse_start();
        begin
            bit seen3, seen8;
            seen3 = 1'b0;
            seen8 = 1'b0;
            for (int f = 0; f < 1500 && !seen8; f++) begin
                int p;
                if (m_over) pulse_start();
                p = clampp(m_y - 40);
                do_frame(p, p);
                check_model("track");
                if (m_hits >= 3 && !seen3) begin
                    seen3 = 1'b1;
                    chk("vx_after_3_hits", iabs($signed(ball_vx)), EXP_VX3);
                end
                if (m_hits >= 8) begin
                    seen8 = 1'b1;
                    chk("vx_after_8_hits", iabs($signed(ball_vx)), EXP_VX8);
                end
            end
            if (!seen8) chk("track.hit_budget", m_hits, 8);
        end

        // Play a full game with paddles out of reach
        do_reset();
        pulse_start();
        for (int f = 0; f < 800 && !m_over; f++) begin
            do_frame(60000, 60000);
            check_model("game");
        end
        chk("end.game_over", int'(game_over), 1);
        chk("end.score1", int'(score1), 7);
        chk("end.score2", int'(score2), 0);
        chk("end.busy", int'(busy), 0);
        idle_tick_ignored("idle_after_win");
        pulse_start();
        chk("restart.game_over", int'(game_over), 0);
        chk("restart.scores", int'({score1, score2}), 0);
        chk("restart.vx", $signed(ball_vx), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
